// File: rtl/frame_loader_mini.sv
// Ping-pong I/Q frame buffer feeding generator_mini with channel-planar words (I[0..N-1], Q[0..N-1]).
// Define INPUT_SCALE_EN to round/shift/saturate each sample by IN_SHIFT before it is stored.
module frame_loader_mini #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 16,
    parameter int IN_SHIFT   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_i_data,
    input  logic [DATA_WIDTH-1:0] s_q_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  gen_start,
    output logic [DATA_WIDTH-1:0] gen_data,
    output logic [DATA_WIDTH-1:0] gen_cond,
    output logic                  gen_valid,
    input  logic                  gen_ready,
    input  logic                  gen_busy,
    input  logic                  gen_done,
    output logic [15:0]           frame_cnt
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_START  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;
    localparam logic [AW:0] LAST_WORD = (AW+1)'(2*FRAME_LEN-1);

    if (FRAME_LEN < 4 || (FRAME_LEN & (FRAME_LEN-1)) != 0) begin : g_bad_len
        $error("frame_loader_mini: FRAME_LEN must be a power of 2 and >= 4");
    end
    if (IN_SHIFT < 0 || IN_SHIFT >= DATA_WIDTH) begin : g_bad_shift
        $error("frame_loader_mini: IN_SHIFT must be in 0..DATA_WIDTH-1");
    end

`ifdef INPUT_SCALE_EN
    localparam logic signed [DATA_WIDTH:0] RND = (DATA_WIDTH+1)'((2**IN_SHIFT)/2);

    // One guard bit keeps the rounding add exact; clamp if the shifted value leaves DATA_WIDTH range.
    function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] x);
        logic signed [DATA_WIDTH:0] sum;
        sum = $signed({x[DATA_WIDTH-1], x}) + RND;
        sum = sum >>> IN_SHIFT;
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
            scale = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
            scale = sum[DATA_WIDTH-1:0];
    endfunction
`else
    function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] x);
        scale = x;
    endfunction
`endif

    logic [DATA_WIDTH-1:0] mem_i_q [2][FRAME_LEN];
    logic [DATA_WIDTH-1:0] mem_q_q [2][FRAME_LEN];

    logic [1:0]            full_q, full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [AW-1:0]         wr_idx_q, wr_idx_d;
    logic [AW:0]           rd_idx_q, rd_idx_d;
    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  wr_fire, rd_fire, load_word;
    logic [DATA_WIDTH-1:0] rd_word;

    assign s_ready   = !full_q[wr_bank_q];
    assign wr_fire   = s_valid && s_ready;
    assign rd_fire   = valid_q && gen_ready;
    assign gen_start = (state_q == ST_START);
    assign gen_data  = data_q;
    assign gen_cond  = data_q;
    assign gen_valid = valid_q;
    assign frame_cnt = frame_cnt_q;

    // Write side; a release from WAIT_DONE always targets the other bank, so both updates can coexist.
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        if (wr_fire) begin
            if (wr_idx_q == AW'(FRAME_LEN-1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_idx_d          = '0;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
        if (state_q == ST_WAIT && gen_done)
            full_d[rd_bank_q] = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        rd_bank_d   = rd_bank_q;
        valid_d     = valid_q;
        frame_cnt_d = frame_cnt_q;
        load_word   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q] && !gen_busy)
                    state_d = ST_START;
            end
            ST_START: begin
                rd_idx_d  = '0;
                valid_d   = 1'b1;
                load_word = 1'b1;
                state_d   = ST_STREAM;
            end
            ST_STREAM: begin
                if (rd_fire) begin
                    if (rd_idx_q == LAST_WORD) begin
                        valid_d = 1'b0;
                        state_d = ST_WAIT;
                    end else begin
                        rd_idx_d  = rd_idx_q + 1'b1;
                        load_word = 1'b1;
                    end
                end
            end
            default: begin
                if (gen_done) begin
                    rd_bank_d   = !rd_bank_q;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    // Index MSB selects the Q plane: words 0..N-1 are I, N..2N-1 are Q.
    assign rd_word = rd_idx_d[AW] ? mem_q_q[rd_bank_q][rd_idx_d[AW-1:0]]
                                  : mem_i_q[rd_bank_q][rd_idx_d[AW-1:0]];
    assign data_d  = load_word ? rd_word : data_q;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_i_q[wr_bank_q][wr_idx_q] <= scale(s_i_data);
            mem_q_q[wr_bank_q][wr_idx_q] <= scale(s_q_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            state_q     <= ST_IDLE;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            state_q     <= state_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end
endmodule

// File: tb/tb_frame_loader_mini.sv
// Directed bench for frame_loader_mini: reset, single frame, backpressure, ping-pong fill, mid-stream reset, scaling.
module tb_frame_loader_mini;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_i_data = '0, s_q_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        gen_start;
    logic [15:0] gen_data, gen_cond;
    logic        gen_valid;
    logic        gen_ready = 1'b0, gen_busy = 1'b0, gen_done = 1'b0;
    logic [15:0] frame_cnt;

    int          n_chk = 0, n_err = 0;
    logic [15:0] words[$];
    logic [15:0] expw[$];
    int          wcyc[$];
    int          cyc = 0, starts = 0, cond_bad = 0, hold_bad = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    bit          bp_en = 1'b0;

    frame_loader_mini dut (
        .clk(clk), .rst_n(rst_n), .s_i_data(s_i_data), .s_q_data(s_q_data),
        .s_valid(s_valid), .s_ready(s_ready), .gen_start(gen_start),
        .gen_data(gen_data), .gen_cond(gen_cond), .gen_valid(gen_valid),
        .gen_ready(gen_ready), .gen_busy(gen_busy), .gen_done(gen_done),
        .frame_cnt(frame_cnt)
    );

    initial forever #5 clk = ~clk;

    // Monitor on the falling edge: what it sees is what the next rising edge will act on.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (gen_start) starts++;
        if (gen_valid && gen_cond !== gen_data) cond_bad++;
        if (prev_stall && (!gen_valid || gen_data !== prev_data)) hold_bad++;
        prev_stall = gen_valid && !gen_ready;
        prev_data  = gen_data;
        if (gen_valid && gen_ready) begin
            words.push_back(gen_data);
            wcyc.push_back(cyc);
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (bp_en) gen_ready = ~gen_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [15:0] es(input logic [15:0] x);
`ifdef INPUT_SCALE_EN
        logic signed [16:0] s;
        s = $signed({x[15], x}) + 17'sd2;
        s = s >>> 2;
        return s[15:0];
`else
        return x;
`endif
    endfunction

    task automatic send_pair(input logic [15:0] i, input logic [15:0] q);
        bit ok = 1'b0;
        s_i_data = i;
        s_q_data = q;
        s_valid  = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = s_ready;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic feed_frame(input int bi, input int bq);
        for (int k = 0; k < 16; k++) send_pair(16'(bi + k), 16'(bq + k));
        for (int k = 0; k < 16; k++) expw.push_back(es(16'(bi + k)));
        for (int k = 0; k < 16; k++) expw.push_back(es(16'(bq + k)));
    endtask

    task automatic wait_words(input int n);
        for (int t = 0; t < 500 && words.size() < n; t++) @(posedge clk);
        #1;
        chk($sformatf("wait_words%0d", n), words.size(), n);
    endtask

    task automatic done_pulse();
        @(posedge clk); #1; gen_done = 1'b1;
        @(posedge clk); #1; gen_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cmp_words(input string tag);
        chk({tag, "_n"}, words.size(), expw.size());
        for (int i = 0; i < expw.size() && i < words.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), words[i], expw[i]);
        words.delete();
        expw.delete();
        wcyc.delete();
    endtask

    initial begin
        // 1: reset
        repeat (10) @(posedge clk);
        #1;
        chk("rst_start", gen_start, 0);
        chk("rst_valid", gen_valid, 0);
        chk("rst_data", gen_data, 0);
        chk("rst_cond", gen_cond, 0);
        chk("rst_fcnt", frame_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_sready", s_ready, 1);

        // 2: single frame, always ready
        gen_ready = 1'b1;
        feed_frame(0, 100);
        wait_words(32);
        chk("t2_starts", starts, 1);
        chk("t2_consec", wcyc[31] - wcyc[0], 31);
        done_pulse();
        chk("t2_fcnt", frame_cnt, 1);
        cmp_words("t2");

        // 3: ready toggling every cycle
        bp_en = 1'b1;
        feed_frame(200, 300);
        wait_words(32);
        bp_en = 1'b0;
        gen_ready = 1'b1;
        done_pulse();
        chk("t3_fcnt", frame_cnt, 2);
        chk("t3_hold", hold_bad, 0);
        chk("t3_starts", starts, 2);
        cmp_words("t3");

        // 4: both banks full while gen_done is withheld
        feed_frame(1000, 1100);
        feed_frame(2000, 2100);
        wait_words(32);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_sready_full", s_ready, 0);
        chk("t4_no_early", words.size(), 32);
        done_pulse();
        chk("t4_sready_rel", s_ready, 1);
        feed_frame(3000, 3100);
        wait_words(64);
        done_pulse();
        wait_words(96);
        done_pulse();
        chk("t4_fcnt", frame_cnt, 5);
        chk("t4_starts", starts, 5);
        cmp_words("t4");

        // 5: reset after word 7 has been accepted
        feed_frame(500, 600);
        wait_words(8);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t5_valid", gen_valid, 0);
        chk("t5_data", gen_data, 0);
        chk("t5_start", gen_start, 0);
        chk("t5_fcnt", frame_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        words.delete();
        expw.delete();
        wcyc.delete();
        @(posedge clk); #1;
        chk("t5_sready", s_ready, 1);
        feed_frame(700, 800);
        wait_words(32);
        done_pulse();
        chk("t5_fcnt1", frame_cnt, 1);
        cmp_words("t5");

        // 6: extreme sample values (scaled or passed through depending on build)
        send_pair(16'h7FFF, 16'h0000);
        send_pair(16'hFFFB, 16'h0000);
        send_pair(16'h0006, 16'h0000);
        send_pair(16'h8000, 16'h0000);
        for (int k = 4; k < 16; k++) send_pair(16'h0000, 16'h0000);
        wait_words(32);
        done_pulse();
`ifdef INPUT_SCALE_EN
        chk("t6_max", words[0], 16'h2000);
        chk("t6_m5", words[1], 16'hFFFF);
        chk("t6_p6", words[2], 16'h0002);
        chk("t6_min", words[3], 16'hE000);
`else
        chk("t6_max", words[0], 16'h7FFF);
        chk("t6_m5", words[1], 16'hFFFB);
        chk("t6_p6", words[2], 16'h0006);
        chk("t6_min", words[3], 16'h8000);
`endif
        chk("t6_q0", words[16], 16'h0000);
        chk("t6_fcnt", frame_cnt, 2);

        chk("cond_eq_data", cond_bad, 0);
        chk("hold_total", hold_bad, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
